// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display path: segment patterns,
// the digit decoder and the converter state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        SHIFT   = 2'd1,
        LOAD    = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_DIGIT[0];
            4'd1:    s = SEG_DIGIT[1];
            4'd2:    s = SEG_DIGIT[2];
            4'd3:    s = SEG_DIGIT[3];
            4'd4:    s = SEG_DIGIT[4];
            4'd5:    s = SEG_DIGIT[5];
            4'd6:    s = SEG_DIGIT[6];
            4'd7:    s = SEG_DIGIT[7];
            4'd8:    s = SEG_DIGIT[8];
            4'd9:    s = SEG_DIGIT[9];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter. Runs back-to-back conversions,
// one every VW+2 cycles, and pulses upd when a finished result is presented.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VW     = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VW-1:0]       value,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic                upd
);

    localparam int              BW    = 4 * DIGITS;
    localparam int              CW    = $clog2(VW + 1);
    localparam logic [63:0]     LIMIT = pow10(DIGITS);
    localparam logic [CW-1:0]   LAST  = CW'(VW - 1);

    conv_state_t   state_r;
    logic [VW-1:0] bin_r;
    logic [BW-1:0] acc_r;
    logic          ovf_r;
    logic [CW-1:0] cnt_r;
    logic          upd_r;
    logic [BW-1:0] adj_s;

    // Add-3 correction on every nibble that would overflow a decimal digit when doubled
    always_comb begin
        adj_s = acc_r;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_r[4*d +: 4] >= 4'd5) begin
                adj_s[4*d +: 4] = acc_r[4*d +: 4] + 4'd3;
            end else begin
                adj_s[4*d +: 4] = acc_r[4*d +: 4];
            end
        end
    end

    // Converter FSM: capture the input, shift VW times, then present the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CAPTURE;
            bin_r   <= '0;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            cnt_r   <= '0;
            upd_r   <= 1'b0;
        end else begin
            case (state_r)
                CAPTURE: begin
                    bin_r   <= value;
                    acc_r   <= '0;
                    ovf_r   <= (64'(value) >= LIMIT);
                    cnt_r   <= '0;
                    upd_r   <= 1'b0;
                    state_r <= SHIFT;
                end
                SHIFT: begin
                    acc_r <= {adj_s[BW-2:0], bin_r[VW-1]};
                    bin_r <= {bin_r[VW-2:0], 1'b0};
                    if (cnt_r == LAST) begin
                        upd_r   <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        cnt_r   <= cnt_r + 1'b1;
                        upd_r   <= 1'b0;
                    end
                end
                LOAD: begin
                    upd_r   <= 1'b0;
                    state_r <= CAPTURE;
                end
                default: begin
                    upd_r   <= 1'b0;
                    state_r <= CAPTURE;
                end
            endcase
        end
    end

    assign bcd = acc_r;
    assign ovf = ovf_r;
    assign upd = upd_r;

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed active-low 7-segment display driven from a binary value: BCD conversion,
// digit scanning, leading-zero blanking and overflow dashes.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int VW       = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VW-1:0]     value,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              upd
);

    localparam int                PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1'b1);

    logic [4*DIGITS-1:0] bcd_s;
    logic                ovf_s;
    logic                upd_s;
    logic [PW-1:0]       presc_r;
    logic [IW-1:0]       idx_r;
    logic [4*DIGITS-1:0] disp_r;
    logic                disp_ovf_r;
    logic [DIGITS-1:0]   an_r;
    logic [6:0]          seg_r;
    logic [DIGITS-1:0]   lead_zero_s;
    logic                zrun_s;
    logic [3:0]          nib_s;
    logic [6:0]          seg_s;

    bin2bcd_seq #(
        .VW     (VW),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .bcd   (bcd_s),
        .ovf   (ovf_s),
        .upd   (upd_s)
    );

    // Scan timebase: dwell SCAN_DIV cycles per digit, then move to the next digit
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (presc_r == PRE_LAST) begin
            presc_r <= '0;
            idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
        end else begin
            presc_r <= presc_r + 1'b1;
        end
    end

    // Display register only takes complete conversion results
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_r     <= '0;
            disp_ovf_r <= 1'b0;
        end else if (upd_s) begin
            disp_r     <= bcd_s;
            disp_ovf_r <= ovf_s;
        end else begin
            disp_r     <= disp_r;
            disp_ovf_r <= disp_ovf_r;
        end
    end

    // lead_zero_s[k]: digit k and every digit above it are zero
    always_comb begin
        zrun_s      = 1'b1;
        lead_zero_s = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zrun_s         = zrun_s & (disp_r[4*k +: 4] == 4'd0);
            lead_zero_s[k] = zrun_s;
        end
    end

    // Segment pattern for the digit currently selected
    always_comb begin
        nib_s = 4'(disp_r >> {idx_r, 2'b00});
        if (disp_ovf_r) begin
            seg_s = SEG_DASH;
        end else if ((BLANK != 0) && (idx_r != '0) && lead_zero_s[idx_r]) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_decode(nib_s);
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= '1;
            seg_r <= SEG_BLANK;
        end else begin
            an_r  <= ~(AN_ONE << idx_r);
            seg_r <= seg_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign upd = upd_s;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display (VW=14, DIGITS=4, SCAN_DIV=4, BLANK=1)
// against a decimal-arithmetic reference of what each digit should show.
module tb_seg7_scan_display;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] value = 14'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        upd;

    int total = 0;
    int bad   = 0;

    logic [6:0] pat [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    seg7_scan_display #(
        .VW       (14),
        .DIGITS   (4),
        .SCAN_DIV (4),
        .BLANK    (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .an    (an),
        .seg   (seg),
        .upd   (upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What digit k of a 4-digit display must show for value v
    function automatic logic [6:0] exp_seg(input int v, input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (v >= 10000) return 7'b0111111;
        if (k > 0 && v < p) return 7'h7F;
        return pat[(v / p) % 10];
    endfunction

    task automatic wait_upd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (upd !== 1'b1 && n < 40);
        chk("upd_seen", upd, 1);
    endtask

    // Called at the negedge where upd is high; checks the scan until the next upd
    task automatic scan_check(input int v, input string tag);
        int  prev_k;
        int  run;
        int  k;
        bit  changed;
        prev_k  = -1;
        run     = 0;
        changed = 1'b0;
        @(negedge clk);
        chk({tag, "_upd_width"}, upd, 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            k = -1;
            for (int j = 0; j < DIGITS; j++) begin
                if (an === ~(4'b0001 << j)) k = j;
            end
            chk({tag, "_an_onehot"}, (k >= 0), 1);
            if (k >= 0) begin
                chk($sformatf("%s_seg_d%0d", tag, k), seg, exp_seg(v, k));
                if (k == prev_k) begin
                    run++;
                end else begin
                    if (prev_k >= 0) begin
                        chk({tag, "_an_order"}, k, (prev_k + 1) % DIGITS);
                        if (changed) chk({tag, "_dwell"}, run, 4);
                        changed = 1'b1;
                    end
                    prev_k = k;
                    run    = 1;
                end
            end
        end
        chk({tag, "_upd_period"}, upd, 1);
    endtask

    // Called at a negedge with reset already applied; releases it and times the first upd
    task automatic release_check(input string tag);
        rst = 1'b0;
        chk({tag, "_upd_c1"}, upd, 0);
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            chk($sformatf("%s_upd_c%0d", tag, c), upd, (c == 16));
        end
    endtask

    task automatic show(input int v);
        int n;
        value = 14'(v);
        wait_upd(n);
        wait_upd(n);
        chk("show_period", n, 16);
        scan_check(v, $sformatf("v%0d", v));
    endtask

    initial begin
        int          n;
        logic [13:0] rv;

        rst   = 1'b1;
        value = 14'd1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_upd", upd, 0);
        release_check("first");
        scan_check(1234, "v1234");

        show(7);
        show(0);
        show(10000);
        show(16383);
        show(9999);
        for (int i = 0; i < 4; i++) begin
            rv = 14'($urandom_range(0, 9999));
            show(int'(rv));
        end
        for (int i = 0; i < 3; i++) begin
            rv = 14'($urandom_range(0, 16383));
            show(int'(rv));
        end

        // Reset during SHIFT cycle 8 aborts the conversion
        value = 14'd4321;
        wait_upd(n);
        wait_upd(n);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        value = 14'd2468;
        release_check("midrst");
        scan_check(2468, "midrst");

        // Input change mid-conversion only affects the following capture
        value = 14'd1234;
        wait_upd(n);
        wait_upd(n);
        repeat (5) @(negedge clk);
        value = 14'd5678;
        wait_upd(n);
        chk("midchg_latency", n, 11);
        scan_check(1234, "midchg_old");
        scan_check(5678, "midchg_new");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
